// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM read arbiter.
// Requester ids double as read tags, so a tag is a single bit.
package sdram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    localparam logic RQ_SCAN = 1'b0;
    localparam logic RQ_DBG  = 1'b1;
    localparam int   TAG_W   = 1;

    function automatic logic [1:0] tag_onehot(input logic tag);
        return tag ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Synchronous tag FIFO remembering which requester owns each outstanding read.
// Push on a full FIFO is only honoured when a pop happens in the same cycle.
module rd_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == CNT_W'(0));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage, pointers (power-of-2 depth, so they wrap naturally) and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read master between the scan
// master and the debug reader; returned data is routed back by queued tag.
module sdram_rd_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int MAX_PEND = 4,
    localparam int CNT_W    = $clog2(MAX_PEND) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          rq_read,
    input  logic [2*ADDR_W-1:0] rq_address,
    output logic [1:0]          rq_waitrequest,
    output logic [DATA_W-1:0]   rq_readdata,
    output logic [1:0]          rq_readdatavalid,
    output logic                avm_read,
    output logic [ADDR_W-1:0]   avm_address,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [CNT_W-1:0]    pend_count,
    output logic                err_unexpected
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic [TAG_W-1:0] fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    rd_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .din     (owner_q),
        .dout    (fifo_dout_s),
        .count   (pend_count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign rq_readdata    = avm_readdata;
    assign err_unexpected = err_q;

    // Arbitration and issue FSM; the accept handshake is combinational
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        fifo_push_s    = 1'b0;
        avm_read       = 1'b0;
        avm_address    = '0;
        rq_waitrequest = 2'b11;
        case (state_q)
            IDLE: begin
                if ((rq_read != 2'b00) && !fifo_full_s) begin
                    if (rq_read == 2'b11) begin
                        owner_d = rr_ptr_q;
                    end else begin
                        owner_d = rq_read[RQ_DBG] ? RQ_DBG : RQ_SCAN;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                avm_read = 1'b1;
                if (owner_q == RQ_DBG) begin
                    avm_address = rq_address[2*ADDR_W-1:ADDR_W];
                end else begin
                    avm_address = rq_address[ADDR_W-1:0];
                end
                if (!avm_waitrequest) begin
                    rq_waitrequest = ~tag_onehot(owner_q);
                    fifo_push_s    = 1'b1;
                    rr_ptr_d       = ~owner_q;
                    state_d        = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Return path: route data by the oldest tag, flag data nobody asked for
    always_comb begin
        fifo_pop_s       = 1'b0;
        rq_readdatavalid = 2'b00;
        err_d            = err_q;
        if (avm_readdatavalid) begin
            if (!fifo_empty_s) begin
                fifo_pop_s       = 1'b1;
                rq_readdatavalid = tag_onehot(fifo_dout_s);
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = err_q;
        end
    end

    // State, ownership, round-robin pointer and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= RQ_SCAN;
            rr_ptr_q <= RQ_SCAN;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Self-checking bench for sdram_rd_arbiter: directed cycles plus a tag
// scoreboard that checks the routing of every returned read.
module tb_sdram_rd_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = $clog2(MAX_PEND) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        rq_read;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        rq_waitrequest;
    logic [DATA_W-1:0] rq_readdata;
    logic [1:0]        rq_readdatavalid;
    logic              avm_read;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [CNT_W-1:0]  pend_count;
    logic              err_unexpected;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_tag_q[$];

    sdram_rd_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rq_read           (rq_read),
        .rq_address        ({addr1, addr0}),
        .rq_waitrequest    (rq_waitrequest),
        .rq_readdata       (rq_readdata),
        .rq_readdatavalid  (rq_readdatavalid),
        .avm_read          (avm_read),
        .avm_address       (avm_address),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .pend_count        (pend_count),
        .err_unexpected    (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge
    task automatic cyc(input logic [1:0] rd, input logic wr, input logic rdv, input logic [31:0] d);
        @(posedge clk);
        #1;
        rq_read           = rd;
        avm_waitrequest   = wr;
        avm_readdatavalid = rdv;
        avm_readdata      = d;
        @(negedge clk);
    endtask

    task automatic expect_bus(input string tag, input logic ar, input logic [1:0] wq, input logic [CNT_W-1:0] pc);
        check_val({tag, ".avm_read"}, 64'(avm_read), 64'(ar));
        check_val({tag, ".waitreq"}, 64'(rq_waitrequest), 64'(wq));
        check_val({tag, ".pend"}, 64'(pend_count), 64'(pc));
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        rq_read           = 2'b00;
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        exp_tag_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard: every controller data beat must go to the oldest expected tag
    always @(negedge clk) begin
        if (reset_n && avm_readdatavalid) begin
            if (exp_tag_q.size() > 0) begin
                logic t;
                t = exp_tag_q.pop_front();
                check_val("sb.route", 64'(rq_readdatavalid), 64'(t ? 2'b10 : 2'b01));
                check_val("sb.rdata", 64'(rq_readdata), 64'(avm_readdata));
            end else begin
                check_val("sb.unexpected", 64'(rq_readdatavalid), 64'(0));
            end
        end else if (reset_n && (rq_readdatavalid != 2'b00)) begin
            check_val("sb.spurious", 64'(rq_readdatavalid), 64'(0));
        end
    end

    initial begin
        int acc;
        addr0 = '0;
        addr1 = '0;
        reset_n           = 1'b0;
        rq_read           = 2'b00;
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        #12;
        expect_bus("rst", 1'b0, 2'b11, 3'd0);
        check_val("rst.addr", 64'(avm_address), 64'(0));
        check_val("rst.rdv", 64'(rq_readdatavalid), 64'(0));
        check_val("rst.err", 64'(err_unexpected), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single read with two wait states, data three cycles after accept
        addr0 = 32'h100;
        cyc(2'b01, 1'b1, 1'b0, 32'h0); expect_bus("t1.idle", 1'b0, 2'b11, 3'd0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0); expect_bus("t1.wait1", 1'b1, 2'b11, 3'd0);
        check_val("t1.addr", 64'(avm_address), 64'(32'h100));
        cyc(2'b01, 1'b1, 1'b0, 32'h0); expect_bus("t1.wait2", 1'b1, 2'b11, 3'd0);
        exp_tag_q.push_back(1'b0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0); expect_bus("t1.accept", 1'b1, 2'b10, 3'd0);
        cyc(2'b00, 1'b1, 1'b0, 32'h0); expect_bus("t1.post", 1'b0, 2'b11, 3'd1);
        cyc(2'b00, 1'b1, 1'b0, 32'h0);
        cyc(2'b00, 1'b1, 1'b1, 32'hDEADBEEF); expect_bus("t1.ret", 1'b0, 2'b11, 3'd1);
        check_val("t1.rdv", 64'(rq_readdatavalid), 64'(2'b01));
        check_val("t1.rdata", 64'(rq_readdata), 64'(32'hDEADBEEF));
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t1.pend0", 64'(pend_count), 64'(0));

        // Simultaneous requests straight after reset: requester 0 first
        do_reset();
        addr0 = 32'h10;
        addr1 = 32'h20;
        cyc(2'b11, 1'b0, 1'b0, 32'h0); expect_bus("t2.idle", 1'b0, 2'b11, 3'd0);
        exp_tag_q.push_back(1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0); expect_bus("t2.acc0", 1'b1, 2'b10, 3'd0);
        check_val("t2.addr0", 64'(avm_address), 64'(32'h10));
        cyc(2'b10, 1'b0, 1'b0, 32'h0); expect_bus("t2.idle2", 1'b0, 2'b11, 3'd1);
        exp_tag_q.push_back(1'b1);
        cyc(2'b10, 1'b0, 1'b0, 32'h0); expect_bus("t2.acc1", 1'b1, 2'b01, 3'd1);
        check_val("t2.addr1", 64'(avm_address), 64'(32'h20));
        cyc(2'b00, 1'b1, 1'b1, 32'hA); check_val("t2.rdvA", 64'(rq_readdatavalid), 64'(2'b01));
        cyc(2'b00, 1'b1, 1'b1, 32'hB); check_val("t2.rdvB", 64'(rq_readdatavalid), 64'(2'b10));
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t2.pend0", 64'(pend_count), 64'(0));

        // Continuous contention with no returns: four accepts then stall
        addr0 = 32'h300;
        addr1 = 32'h400;
        exp_tag_q.push_back(1'b0); exp_tag_q.push_back(1'b1);
        exp_tag_q.push_back(1'b0); exp_tag_q.push_back(1'b1);
        acc = 0;
        for (int k = 1; k <= 12; k++) begin
            logic       exp_acc;
            logic       own;
            logic [1:0] exp_wq;
            cyc(2'b11, 1'b0, 1'b0, 32'h0);
            exp_acc = ((k % 2) == 0) && (k <= 8);
            own     = 1'(((k / 2) - 1) % 2);
            exp_wq  = exp_acc ? (own ? 2'b01 : 2'b10) : 2'b11;
            check_val($sformatf("t3.read%0d", k), 64'(avm_read), 64'(exp_acc));
            check_val($sformatf("t3.wq%0d", k), 64'(rq_waitrequest), 64'(exp_wq));
            if (rq_waitrequest != 2'b11) acc++;
        end
        check_val("t3.accepts", 64'(acc), 64'(4));
        check_val("t3.stall", 64'(avm_read), 64'(0));
        check_val("t3.full", 64'(pend_count), 64'(4));
        cyc(2'b11, 1'b0, 1'b1, 32'h1000); expect_bus("t3.pop", 1'b0, 2'b11, 3'd4);
        cyc(2'b11, 1'b0, 1'b0, 32'h0); expect_bus("t3.grant", 1'b0, 2'b11, 3'd3);
        exp_tag_q.push_back(1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0); expect_bus("t3.regrant", 1'b1, 2'b10, 3'd3);
        check_val("t3.addr", 64'(avm_address), 64'(32'h300));
        cyc(2'b00, 1'b0, 1'b1, 32'h1001); check_val("t3.refull", 64'(pend_count), 64'(4));
        cyc(2'b00, 1'b0, 1'b1, 32'h1002); check_val("t3.drain", 64'(pend_count), 64'(3));

        // Accept and return in the same cycle with two reads pending
        addr0 = 32'h500;
        cyc(2'b01, 1'b0, 1'b0, 32'h0); expect_bus("t4.idle", 1'b0, 2'b11, 3'd2);
        exp_tag_q.push_back(1'b0);
        cyc(2'b01, 1'b0, 1'b1, 32'h44); expect_bus("t4.both", 1'b1, 2'b10, 3'd2);
        check_val("t4.head", 64'(rq_readdatavalid), 64'(2'b10));
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t4.pend", 64'(pend_count), 64'(2));
        cyc(2'b00, 1'b1, 1'b1, 32'h55);
        cyc(2'b00, 1'b1, 1'b1, 32'h66);
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t4.pend0", 64'(pend_count), 64'(0));

        // Data with nothing outstanding raises the sticky error
        cyc(2'b00, 1'b1, 1'b1, 32'h77);
        check_val("t5.rdv", 64'(rq_readdatavalid), 64'(0));
        check_val("t5.err_before", 64'(err_unexpected), 64'(0));
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t5.err", 64'(err_unexpected), 64'(1));
        repeat (3) cyc(2'b00, 1'b1, 1'b0, 32'h0);
        check_val("t5.sticky", 64'(err_unexpected), 64'(1));

        // Reset while issuing with two reads pending
        addr0 = 32'h600;
        addr1 = 32'h700;
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        exp_tag_q.push_back(1'b0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        exp_tag_q.push_back(1'b0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0); expect_bus("t6.issue", 1'b1, 2'b11, 3'd2);
        reset_n = 1'b0;
        exp_tag_q.delete();
        #1;
        expect_bus("t6.rst", 1'b0, 2'b11, 3'd0);
        check_val("t6.err", 64'(err_unexpected), 64'(0));
        @(posedge clk);
        #1;
        reset_n         = 1'b1;
        rq_read         = 2'b11;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check_val("t6.idle", 64'(avm_read), 64'(0));
        exp_tag_q.push_back(1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0);
        check_val("t6.first_grant", 64'(rq_waitrequest), 64'(2'b10));
        check_val("t6.addr", 64'(avm_address), 64'(32'h600));
        cyc(2'b00, 1'b1, 1'b1, 32'h88);
        cyc(2'b00, 1'b1, 1'b0, 32'h0); check_val("t6.pend0", 64'(pend_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
